func_eval_sequencer: RTL and testbench
======================================

// Module: func_eval_sequencer
// PURPOSE
//  Command front-end and scheduler for the two-operand function-evaluation pipeline
//  (stage_1 -> CORDIC stage_2 -> stage_3 -> stage_4 accumulators).
//  Decodes custom-instruction opcodes (CLEAR/GO/READ) and buffers GO operand pairs in a
//  small FIFO. Issues pairs to stage_1 under back-pressure, tracks pairs still in flight,
//  and drains the pipeline before READ or CLEAR completes. Sits between the CPU
//  custom-instruction port and the datapath.
// PARAMETERS
//  FLT_DATA_WIDTH   32  operand/result width (IEEE-754 single)
//  N_WIDTH          2   opcode width
//  FIFO_DEPTH       4   operand-pair FIFO entries (power of 2)
//  MAX_OUTSTANDING  8   pairs allowed between s1_start and retire
//  CNT_WIDTH        4   outstanding-counter width (>= clog2(MAX_OUTSTANDING+1))
//  TIMEOUT_CYCLES   1024 drain watchdog limit (FEVAL_SEQ_TIMEOUT_EN only)
// PORTS
//  clk        in   1    clock
//  rst        in   1    asynchronous reset, active-low
//  clk_en     in   1    qualifies start
//  start      in   1    command strobe
//  n          in   2    opcode: 0 CLEAR, 1 GO, 2 READ, 3 reserved (NOP, done only)
//  dataa      in   32   GO operand x_one
//  datab      in   32   GO operand x_two
//  result     out  32   READ result; 0 for GO/CLEAR
//  done       out  1    one-cycle completion pulse per command
//  s1_start   out  1    one-cycle pulse into stage_1
//  s1_x_one   out  32   FIFO head x_one, valid with s1_start
//  s1_x_two   out  32   FIFO head x_two, valid with s1_start
//  s1_busy    in   1    stage_1 working; no issue while high
//  retire     in   1    pulse: one pair fully accumulated (stage_4 done)
//  pipe_empty in   1    all pipeline stages idle
//  fin_start  out  1    pulse: start final combine of accumulators
//  fin_done   in   1    final combine complete
//  fin_sum    in   32   final combine value, valid with fin_done
//  acc_clear  out  1    one-cycle pulse: zero accumulators
//  timeout    out  1    sticky watchdog flag (FEVAL_SEQ_TIMEOUT_EN only)
// BEHAVIOUR
//  Reset: all outputs 0, FIFO empty, outstanding=0, state IDLE. Reset mid-command
//   discards all in-flight work and issues no done.
//  Command FSM states: IDLE, GO_WAIT, DRAIN, FIN_WAIT, CLR, RESP.
//  - IDLE: accept when start&clk_en. Commands issued while not in IDLE are ignored.
//  - GO: FIFO not full -> write {dataa,datab} and go to RESP; done=1 on the next cycle.
//    FIFO full -> GO_WAIT holds the operands and writes them once space frees, then RESP.
//  - READ/CLEAR: -> DRAIN. DRAIN exits when FIFO empty & outstanding==0 & pipe_empty.
//    READ exits to FIN_WAIT; CLEAR exits to CLR.
//  - FIN_WAIT: fin_start pulses on entry cycle. On fin_done, result<=fin_sum -> RESP.
//  - CLR: acc_clear pulses one cycle -> RESP, with result=0.
//  - RESP: done=1 for one cycle -> IDLE.
//  Issue engine runs independently every cycle (not gated by clk_en). It pulses s1_start
//   and pops when FIFO non-empty & !s1_busy & outstanding<MAX_OUTSTANDING & s1_start==0.
//   This gives at most one issue every 2 cycles.
//  outstanding: +1 on s1_start, -1 on retire, unchanged if both occur in the same cycle.
//   retire at 0 is ignored (saturates).
//  FIFO simultaneous push+pop: allowed when full (pop frees the slot the same cycle).
//  Latency: GO done = 1 cycle after accept (no stall). READ done = drain + fin latency + 1.
// CONFIGURATION
//  `FEVAL_SEQ_TIMEOUT_EN defined: a DRAIN counter runs. When it reaches TIMEOUT_CYCLES:
//   timeout<=1 (sticky until rst), outstanding<=0, FIFO flushed.
//   READ returns 0x7FC00000 (qNaN) without fin_start; CLEAR proceeds to CLR.
//  Undefined: no counter, timeout tied 0, DRAIN waits indefinitely.
// STRUCTURE
//  Package func_eval_pkg: opcode constants CLEAR/GO/READ, FSM state encodings,
//   FLT_DATA_WIDTH, QNAN constant.
//  Sub-module func_eval_op_fifo: 2*FLT_DATA_WIDTH wide, FIFO_DEPTH deep, registered
//   full/empty.
// TESTING
//  1 GO dataa=0x3F800000 datab=0x40000000, s1_busy=0 -> done at T+1; s1_start within
//    2 cycles with those values.
//  2 Five back-to-back GOs, s1_busy=1 -> four done pulses. Fifth done only after s1_busy
//    drops and a pop occurs.
//  3 READ with 2 outstanding -> no fin_start until 2 retires and pipe_empty=1.
//    fin_sum=0x40400000 -> result=0x40400000, done 1 cycle after fin_done.
//  4 CLEAR on idle pipe -> acc_clear 1 cycle, done next cycle, result=0.
//  5 retire coincident with s1_start at outstanding=3 -> stays 3. retire at 0 -> stays 0.
//  6 rst low during DRAIN -> all outputs 0 immediately, no done.
//    With FEVAL_SEQ_TIMEOUT_EN and retire never asserted -> result 0x7FC00000, timeout=1.

Source files
------------

// File: rtl/func_eval_pkg.sv
// Shared opcodes, command-FSM encodings and float constants for the function-evaluation
// sequencer and its operand FIFO.
package func_eval_pkg;

  localparam int FLT_DATA_WIDTH = 32;
  localparam int N_WIDTH        = 2;

  localparam logic [N_WIDTH-1:0] OP_CLEAR = 2'd0;
  localparam logic [N_WIDTH-1:0] OP_GO    = 2'd1;
  localparam logic [N_WIDTH-1:0] OP_READ  = 2'd2;

  localparam logic [FLT_DATA_WIDTH-1:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_GO_WAIT  = 3'd1,
    ST_DRAIN    = 3'd2,
    ST_FIN_WAIT = 3'd3,
    ST_CLR      = 3'd4,
    ST_RESP     = 3'd5
  } state_t;

endpackage

// File: rtl/func_eval_op_fifo.sv
// Operand-pair FIFO with registered full/empty. A push while full is accepted when a pop
// frees the head slot in the same cycle. flush empties it in one cycle.
module func_eval_op_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [AW:0]      count_nxt;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    case ({do_push, do_pop})
      2'b10:   count_nxt = count + (AW+1)'(1);
      2'b01:   count_nxt = count - (AW+1)'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      full  <= (count_nxt == (AW+1)'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  // Storage carries no reset; it is only read behind a non-empty head.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/func_eval_sequencer.sv
// Custom-instruction front-end for the function-evaluation pipeline: decodes CLEAR/GO/READ,
// queues GO pairs, issues them to stage_1 and drains before READ/CLEAR. FEVAL_SEQ_TIMEOUT_EN adds a drain watchdog.
module func_eval_sequencer
  import func_eval_pkg::*;
#(
  parameter int FIFO_DEPTH      = 4,
  parameter int MAX_OUTSTANDING = 8,
  parameter int CNT_WIDTH       = 4,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clk_en,
  input  logic                      start,
  input  logic [N_WIDTH-1:0]        n,
  input  logic [FLT_DATA_WIDTH-1:0] dataa,
  input  logic [FLT_DATA_WIDTH-1:0] datab,
  output logic [FLT_DATA_WIDTH-1:0] result,
  output logic                      done,
  output logic                      s1_start,
  output logic [FLT_DATA_WIDTH-1:0] s1_x_one,
  output logic [FLT_DATA_WIDTH-1:0] s1_x_two,
  input  logic                      s1_busy,
  input  logic                      retire,
  input  logic                      pipe_empty,
  output logic                      fin_start,
  input  logic                      fin_done,
  input  logic [FLT_DATA_WIDTH-1:0] fin_sum,
  output logic                      acc_clear,
  output logic                      timeout,
  output logic [2:0]                dbg_state,
  output logic [CNT_WIDTH-1:0]      dbg_outstanding
);

  // Handshakes: every strobe here (start, s1_start, retire, fin_start, fin_done, done,
  // acc_clear) is a single-cycle pulse sampled on the rising clock edge; s1_busy is a level
  // that blocks issue while high, and payloads are valid only in their strobe's cycle.

  localparam logic [CNT_WIDTH-1:0] MAX_OUT = CNT_WIDTH'(MAX_OUTSTANDING);

  state_t                      state;
  state_t                      state_nxt;
  logic [FLT_DATA_WIDTH-1:0]   hold_a;
  logic [FLT_DATA_WIDTH-1:0]   hold_b;
  logic                        is_read;
  logic [CNT_WIDTH-1:0]        outstanding;
  logic                        accept;
  logic                        issue;
  logic                        drain_ok;
  logic                        dec_ok;
  logic                        tmo_hit;
  logic                        fifo_push;
  logic [2*FLT_DATA_WIDTH-1:0] push_data;
  logic [2*FLT_DATA_WIDTH-1:0] fifo_rdata;
  logic                        fifo_full;
  logic                        fifo_empty;

  func_eval_op_fifo #(
    .WIDTH (2*FLT_DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (tmo_hit),
    .push  (fifo_push),
    .wdata (push_data),
    .pop   (issue),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // The registered s1_start term spaces issues at least two cycles apart.
  assign issue    = !fifo_empty && !s1_busy && (outstanding < MAX_OUT) && !s1_start && !tmo_hit;
  assign drain_ok = fifo_empty && (outstanding == '0) && pipe_empty && !s1_start;
  assign dec_ok   = retire && (outstanding != '0);

  assign done            = (state == ST_RESP);
  assign acc_clear       = (state == ST_CLR);
  assign dbg_state       = state;
  assign dbg_outstanding = outstanding;

  always_comb begin
    state_nxt = state;
    fifo_push = 1'b0;
    push_data = {hold_a, hold_b};
    accept    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && clk_en) begin
          accept = 1'b1;
          case (n)
            OP_GO: begin
              push_data = {dataa, datab};
              if (!fifo_full) begin
                fifo_push = 1'b1;
                state_nxt = ST_RESP;
              end else begin
                state_nxt = ST_GO_WAIT;
              end
            end
            OP_READ, OP_CLEAR: state_nxt = ST_DRAIN;
            default:           state_nxt = ST_RESP;
          endcase
        end
      end
      ST_GO_WAIT: begin
        if (!fifo_full || issue) begin
          fifo_push = 1'b1;
          state_nxt = ST_RESP;
        end
      end
      ST_DRAIN: begin
        if (drain_ok)     state_nxt = is_read ? ST_FIN_WAIT : ST_CLR;
        else if (tmo_hit) state_nxt = is_read ? ST_RESP : ST_CLR;
      end
      ST_FIN_WAIT: if (fin_done) state_nxt = ST_RESP;
      ST_CLR:      state_nxt = ST_RESP;
      ST_RESP:     state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      result      <= '0;
      hold_a      <= '0;
      hold_b      <= '0;
      is_read     <= 1'b0;
      s1_start    <= 1'b0;
      s1_x_one    <= '0;
      s1_x_two    <= '0;
      fin_start   <= 1'b0;
      outstanding <= '0;
    end else begin
      state     <= state_nxt;
      s1_start  <= issue;
      fin_start <= (state == ST_DRAIN) && (state_nxt == ST_FIN_WAIT);
      if (issue) {s1_x_one, s1_x_two} <= fifo_rdata;
      if (accept) begin
        hold_a  <= dataa;
        hold_b  <= datab;
        is_read <= (n == OP_READ);
        result  <= '0;
      end
      if (state == ST_FIN_WAIT && fin_done) result <= fin_sum;
      if (tmo_hit && is_read)               result <= QNAN;
      // A retire landing with an issue cancels out; a retire at zero is dropped.
      if (tmo_hit)                 outstanding <= '0;
      else if (s1_start && !dec_ok) outstanding <= outstanding + CNT_WIDTH'(1);
      else if (!s1_start && dec_ok) outstanding <= outstanding - CNT_WIDTH'(1);
    end
  end

`ifdef FEVAL_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] drain_cnt;

  assign tmo_hit = (state == ST_DRAIN) && !drain_ok && (drain_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drain_cnt <= '0;
      timeout   <= 1'b0;
    end else begin
      if (state == ST_DRAIN && !tmo_hit) drain_cnt <= drain_cnt + TW'(1);
      else                               drain_cnt <= '0;
      if (tmo_hit) timeout <= 1'b1;
    end
  end
`else
  // Without the watchdog DRAIN waits indefinitely; the expression is constant false.
  assign tmo_hit = (TIMEOUT_CYCLES < 0);
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_func_eval_sequencer.sv
// Bench for func_eval_sequencer: command table, directed multi-cycle corners and a random
// phase checked by an issue-order scoreboard and an outstanding-count model.
module tb_func_eval_sequencer;
  import func_eval_pkg::*;

  localparam int MAX_OUT = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clk_en = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  n = 2'd0;
  logic [31:0] dataa = '0;
  logic [31:0] datab = '0;
  logic [31:0] result;
  logic        done;
  logic        s1_start;
  logic [31:0] s1_x_one;
  logic [31:0] s1_x_two;
  logic        s1_busy = 1'b0;
  logic        retire = 1'b0;
  logic        pipe_empty = 1'b1;
  logic        fin_start;
  logic        fin_done = 1'b0;
  logic [31:0] fin_sum = '0;
  logic        acc_clear;
  logic        timeout;
  logic [2:0]  dbg_state;
  logic [3:0]  dbg_outstanding;

  func_eval_sequencer dut (
    .clk (clk), .rst (rst), .clk_en (clk_en), .start (start), .n (n),
    .dataa (dataa), .datab (datab), .result (result), .done (done),
    .s1_start (s1_start), .s1_x_one (s1_x_one), .s1_x_two (s1_x_two),
    .s1_busy (s1_busy), .retire (retire), .pipe_empty (pipe_empty),
    .fin_start (fin_start), .fin_done (fin_done), .fin_sum (fin_sum),
    .acc_clear (acc_clear), .timeout (timeout),
    .dbg_state (dbg_state), .dbg_outstanding (dbg_outstanding)
  );

  // clock/reset
  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] exp_q[$];
  int          model_out = 0;
  bit          mon_en = 1'b0;
  bit          rand_mode = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Scoreboard: pairs leave in GO order; outstanding = issues - retires, retire at 0 ignored.
  always begin
    logic [63:0] e;
    bit          dec;
    @(negedge clk);
    #2;
    if (!rst) begin
      model_out = 0;
      exp_q.delete();
    end else if (mon_en) begin
      check("outstanding", 32'(dbg_outstanding), 32'(model_out));
      if (s1_start) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL issue_no_go: got s1_start=1 want no issue (no pending GO)");
        end else begin
          e = exp_q.pop_front();
          check("s1_x_one", s1_x_one, e[63:32]);
          check("s1_x_two", s1_x_two, e[31:0]);
        end
        check("issue_under_limit", 32'(model_out < MAX_OUT), 32'd1);
      end
      dec = retire && (model_out > 0);
      if (s1_start && !dec)      model_out++;
      else if (!s1_start && dec) model_out--;
    end
  end

  // Random back-pressure and retirement for the random phase.
  always begin
    @(negedge clk);
    if (rand_mode) begin
      s1_busy = ($urandom_range(0, 3) == 0);
      retire  = (model_out > 0) && ($urandom_range(0, 2) == 0);
    end
  end

  // driver tasks
  task automatic send_cmd(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; clk_en = 1'b1; n = op; dataa = a; datab = b;
    if (op == OP_GO) exp_q.push_back({a, b});
  endtask

  task automatic wait_done(input int max_cyc, input logic [31:0] fs, output bit got,
                           output int cyc, output logic [31:0] res, output int fin_at,
                           output int clr_at);
    got = 1'b0; cyc = 0; res = '0; fin_at = -1; clr_at = -1;
    while (!got && cyc < max_cyc) begin
      @(negedge clk);
      start = 1'b0; fin_done = 1'b0;
      cyc++;
      if (acc_clear) clr_at = cyc;
      if (fin_start) begin
        fin_done = 1'b1; fin_sum = fs; fin_at = cyc;
      end
      if (done) begin
        got = 1'b1; res = result;
      end
    end
  endtask

  task automatic pulse_retire();
    @(negedge clk); retire = 1'b1;
    @(negedge clk); retire = 1'b0;
  endtask

  task automatic drain_all();
    int guard = 0;
    repeat (16) @(negedge clk);
    while (model_out > 0 && guard < 30) begin
      pulse_retire();
      guard++;
    end
    repeat (4) @(negedge clk);
    check("drained", 32'(dbg_outstanding), 32'd0);
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] fs;
    logic [31:0] exp_res;
    int          exp_cyc;
    bit          exp_fin;
    bit          exp_clr;
  } vec_t;

  vec_t tbl[6];

  initial begin
    bit          got;
    int          cyc, fin_at, clr_at;
    logic [31:0] res, ra, rb, fs;
    logic [1:0]  op;

    tbl[0] = '{2'd3,    32'h0, 32'h0, 32'h0,         32'h0,         1, 1'b0, 1'b0};
    tbl[1] = '{OP_CLEAR, 32'h0, 32'h0, 32'h0,        32'h0,         3, 1'b0, 1'b1};
    tbl[2] = '{OP_READ, 32'h0, 32'h0, 32'h4040_0000, 32'h4040_0000, 3, 1'b1, 1'b0};
    tbl[3] = '{OP_READ, 32'h0, 32'h0, 32'hC049_0FDB, 32'hC049_0FDB, 3, 1'b1, 1'b0};
    tbl[4] = '{OP_CLEAR, 32'h0, 32'h0, 32'h1234_5678, 32'h0,        3, 1'b0, 1'b1};
    tbl[5] = '{OP_GO,   32'h4120_0000, 32'hBF80_0000, 32'h0, 32'h0, 1, 1'b0, 1'b0};

    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_s1_start", 32'(s1_start), 32'd0);
    check("rst_fin_start", 32'(fin_start), 32'd0);
    check("rst_acc_clear", 32'(acc_clear), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    rst = 1'b1;
    mon_en = 1'b1;

    // First GO: done one cycle after accept, issued on the following cycle.
    send_cmd(OP_GO, 32'h3F80_0000, 32'h4000_0000);
    wait_done(10, '0, got, cyc, res, fin_at, clr_at);
    check("go1_done", 32'(got), 32'd1);
    check("go1_latency", 32'(cyc), 32'd1);
    check("go1_result", res, 32'd0);
    @(negedge clk);
    check("go1_issue", 32'(s1_start), 32'd1);
    pulse_retire();

    for (int i = 0; i < 6; i++) begin
      send_cmd(tbl[i].op, tbl[i].a, tbl[i].b);
      wait_done(50, tbl[i].fs, got, cyc, res, fin_at, clr_at);
      check($sformatf("tbl%0d_done", i), 32'(got), 32'd1);
      check($sformatf("tbl%0d_latency", i), 32'(cyc), 32'(tbl[i].exp_cyc));
      check($sformatf("tbl%0d_result", i), res, tbl[i].exp_res);
      check($sformatf("tbl%0d_fin", i), 32'(fin_at > 0), 32'(tbl[i].exp_fin));
      check($sformatf("tbl%0d_clr", i), 32'(clr_at > 0), 32'(tbl[i].exp_clr));
    end
    check("tbl_timeout", 32'(timeout), 32'd0);
    drain_all();

    // Strobe without clk_en is ignored.
    @(negedge clk);
    start = 1'b1; clk_en = 1'b0; n = OP_GO;
    wait_done(5, '0, got, cyc, res, fin_at, clr_at);
    check("no_clk_en", 32'(got), 32'd0);
    clk_en = 1'b1;

    // Four GOs fill the FIFO under back-pressure; the fifth waits for a pop.
    s1_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send_cmd(OP_GO, $urandom, $urandom);
      wait_done(10, '0, got, cyc, res, fin_at, clr_at);
      check("busy_go_done", 32'(got), 32'd1);
      check("busy_go_latency", 32'(cyc), 32'd1);
    end
    send_cmd(OP_GO, 32'hDEAD_BEEF, 32'h0BAD_F00D);
    wait_done(10, '0, got, cyc, res, fin_at, clr_at);
    check("full_go_held", 32'(got), 32'd0);
    s1_busy = 1'b0;
    wait_done(5, '0, got, cyc, res, fin_at, clr_at);
    check("full_go_done", 32'(got), 32'd1);
    check("full_go_latency", 32'(cyc), 32'd1);
    check("full_go_popped", 32'(s1_start), 32'd1);
    drain_all();

    // READ with two pairs in flight waits for both retires and pipe_empty.
    send_cmd(OP_GO, 32'h3F80_0000, 32'h3F80_0000);
    wait_done(10, '0, got, cyc, res, fin_at, clr_at);
    send_cmd(OP_GO, 32'h4000_0000, 32'h4000_0000);
    wait_done(10, '0, got, cyc, res, fin_at, clr_at);
    repeat (4) @(negedge clk);
    check("read_inflight", 32'(dbg_outstanding), 32'd2);
    pipe_empty = 1'b0;
    send_cmd(OP_READ, '0, '0);
    wait_done(6, 32'h4040_0000, got, cyc, res, fin_at, clr_at);
    check("read_wait_done", 32'(got), 32'd0);
    check("read_wait_fin", 32'(fin_at > 0), 32'd0);
    pulse_retire();
    pulse_retire();
    wait_done(4, 32'h4040_0000, got, cyc, res, fin_at, clr_at);
    check("read_pipe_busy", 32'(got || fin_at > 0), 32'd0);
    pipe_empty = 1'b1;
    wait_done(10, 32'h4040_0000, got, cyc, res, fin_at, clr_at);
    check("read_done", 32'(got), 32'd1);
    check("read_result", res, 32'h4040_0000);
    check("read_fin_start", 32'(fin_at > 0), 32'd1);
    check("read_done_gap", 32'(cyc), 32'(fin_at + 1));

    // CLEAR on idle pipe.
    send_cmd(OP_CLEAR, '0, '0);
    wait_done(10, '0, got, cyc, res, fin_at, clr_at);
    check("clr_done", 32'(got), 32'd1);
    check("clr_result", res, 32'd0);
    check("clr_pulse", 32'(clr_at > 0), 32'd1);
    check("clr_done_gap", 32'(cyc), 32'(clr_at + 1));

    // Retire coincident with issue at outstanding=3, then retire at zero.
    for (int i = 0; i < 3; i++) begin
      send_cmd(OP_GO, $urandom, $urandom);
      wait_done(10, '0, got, cyc, res, fin_at, clr_at);
      repeat (3) @(negedge clk);
    end
    send_cmd(OP_GO, $urandom, $urandom);
    wait_done(10, '0, got, cyc, res, fin_at, clr_at);
    @(negedge clk);
    check("coinc_issue", 32'(s1_start), 32'd1);
    retire = 1'b1;
    @(negedge clk);
    retire = 1'b0;
    #3 check("coinc_hold", 32'(dbg_outstanding), 32'd3);
    for (int i = 0; i < 3; i++) pulse_retire();
    pulse_retire();
    @(negedge clk);
    #3 check("retire_at_zero", 32'(dbg_outstanding), 32'd0);

    // Nine GOs with no retires: issue stops at the outstanding limit.
    for (int i = 0; i < 9; i++) begin
      send_cmd(OP_GO, $urandom, $urandom);
      wait_done(10, '0, got, cyc, res, fin_at, clr_at);
    end
    repeat (10) @(negedge clk);
    check("limit_hold", 32'(dbg_outstanding), 32'(MAX_OUT));
    drain_all();

    // Random phase.
    rand_mode = 1'b1;
    for (int i = 0; i < 30; i++) begin
      op = ($urandom_range(0, 4) == 0) ? OP_READ : OP_GO;
      ra = $urandom; rb = $urandom; fs = $urandom;
      send_cmd(op, ra, rb);
      wait_done(400, fs, got, cyc, res, fin_at, clr_at);
      check("rand_done", 32'(got), 32'd1);
      check("rand_result", res, (op == OP_READ) ? fs : 32'd0);
    end
    @(negedge clk);
    rand_mode = 1'b0; s1_busy = 1'b0; retire = 1'b0;
    drain_all();
    check("rand_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset during DRAIN clears everything and yields no done.
    send_cmd(OP_GO, 32'h1111_1111, 32'h2222_2222);
    wait_done(10, '0, got, cyc, res, fin_at, clr_at);
    repeat (3) @(negedge clk);
    send_cmd(OP_READ, '0, '0);
    wait_done(4, 32'h5555_5555, got, cyc, res, fin_at, clr_at);
    check("pre_rst_no_done", 32'(got), 32'd0);
    check("pre_rst_drain", 32'(dbg_state), 32'(ST_DRAIN));
    rst = 1'b0;
    #1;
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_result", result, 32'd0);
    check("mid_rst_s1_start", 32'(s1_start), 32'd0);
    check("mid_rst_fin_start", 32'(fin_start), 32'd0);
    check("mid_rst_acc_clear", 32'(acc_clear), 32'd0);
    check("mid_rst_state", 32'(dbg_state), 32'd0);
    check("mid_rst_outstanding", 32'(dbg_outstanding), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    wait_done(6, '0, got, cyc, res, fin_at, clr_at);
    check("post_rst_no_done", 32'(got), 32'd0);

`ifdef FEVAL_SEQ_TIMEOUT_EN
    // Watchdog: a pair that never retires forces qNaN for READ.
    mon_en = 1'b0;
    send_cmd(OP_GO, 32'h3F80_0000, 32'h3F80_0000);
    wait_done(10, '0, got, cyc, res, fin_at, clr_at);
    repeat (3) @(negedge clk);
    send_cmd(OP_READ, '0, '0);
    wait_done(1100, 32'h1234_5678, got, cyc, res, fin_at, clr_at);
    check("tmo_done", 32'(got), 32'd1);
    check("tmo_result", res, QNAN);
    check("tmo_no_fin", 32'(fin_at > 0), 32'd0);
    check("tmo_flag", 32'(timeout), 32'd1);
    check("tmo_outstanding", 32'(dbg_outstanding), 32'd0);
    send_cmd(OP_CLEAR, '0, '0);
    wait_done(10, '0, got, cyc, res, fin_at, clr_at);
    check("tmo_clr_done", 32'(got), 32'd1);
    check("tmo_clr_pulse", 32'(clr_at > 0), 32'd1);
    check("tmo_sticky", 32'(timeout), 32'd1);
`else
    check("no_tmo_flag", 32'(timeout), 32'd0);
`endif

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test want finish within 2 ms");
    $fatal(1);
  end

endmodule
